lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter CNT1MS, default 100_000, meaning clk cycles per 1 ms.
REQ-002 SHALL have parameter POWERON_MS, default 20, meaning the power-on wait in ms before the first init command.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n holds a byte for the LCD.
REQ-006 SHALL have ports req0_rs and req1_rs, input, 1 bit each: the RS value for the byte (0 = command, 1 = data).
REQ-007 SHALL have ports req0_data and req1_data, input, 8 bits each: the byte to write.
REQ-008 SHALL have ports req0_ready and req1_ready, output, 1 bit each: a one-cycle accept pulse.
REQ-009 SHALL have port lcd_e, output, 1 bit: the HD44780 enable strobe.
REQ-010 SHALL have port lcd_rs, output, 1 bit: the HD44780 register select.
REQ-011 SHALL have port lcd_rw, output, 1 bit: tied to 0 (write only).
REQ-012 SHALL have port lcd_data, output, 8 bits: the HD44780 data bus.
REQ-013 SHALL have port init_done, output, 1 bit: high once the init sequence has completed.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the states PWRON, INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE, SETUP, PULSE and HOLD.
REQ-016 SHALL time each phase with a 1 ms counter (0..CNT1MS-1) that restarts at 0 on every state entry.
REQ-017 SHALL hold PWRON for POWERON_MS ms, then enter INIT_SETUP with command index 0.
REQ-018 SHALL issue the init commands in order 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02, each with rs=0.
REQ-019 SHALL time each init command as INIT_SETUP 1 ms, then INIT_PULSE 1 ms, then INIT_HOLD 2 ms.
REQ-020 SHALL, after the sixth init command's INIT_HOLD, set init_done=1 and enter IDLE.
REQ-021 SHALL assert no reqN_ready before init_done=1.
REQ-022 SHALL, in IDLE when at least one valid is high, grant exactly one requester and pulse its reqN_ready for one cycle.
REQ-023 SHALL, on a grant, load lcd_rs/lcd_data from the granted requester at the same edge that enters SETUP.
REQ-024 SHALL time each granted transfer as SETUP 1 ms, then PULSE 1 ms, then HOLD 2 ms, then IDLE (4*CNT1MS+1 cycles grant-to-grant minimum).
REQ-025 SHALL drive lcd_e=1 only in PULSE and INIT_PULSE.
REQ-026 SHALL hold lcd_rs and lcd_data stable from SETUP entry through HOLD exit.
REQ-027 SHALL arbitrate round-robin: when both valids are high, grant the requester not granted last.
REQ-028 SHALL grant req0 on the first contention after reset.
REQ-029 SHALL treat a valid that drops before its grant as withdrawn, with no side effect.
REQ-030 SHALL ignore valid and data changes during SETUP, PULSE and HOLD, with no re-latch.
REQ-031 SHALL hold the round-robin pointer unchanged when only one requester is valid, except that the pointer records that grant.

Reset
REQ-032 SHALL, while reset=1 at a clk edge, load state=PWRON (IDLE when the macro is off), init index 0, ms counter 0, and last-grant pointer = req1 (so req0 wins first).
REQ-033 SHALL, while reset=1, drive lcd_e=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0, both ready=0, init_done=0 and busy=1 (busy=0 when the macro is off).
REQ-034 SHALL treat reset mid-transfer as aborting the transfer: lcd_e=0 at the next edge and no ready pulse.
REQ-035 SHALL, after reset mid-transfer, restart from PWRON, discarding any latched byte.

Configuration
REQ-036 SHALL, with macro LCD_ARB_INIT_SEQ_EN defined, include PWRON and the INIT_* states exactly as in REQ-017 to REQ-021.
REQ-037 SHALL, without LCD_ARB_INIT_SEQ_EN, leave reset in IDLE with init_done tied to 1, omit the PWRON and INIT_* logic, and keep all other behaviour identical.

Verification (CNT1MS=4, POWERON_MS=2, macro defined)
REQ-038 SHALL cover: reset release -> lcd_e pulses 6 times, each 4 cycles high, with lcd_data 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02 in that order; init_done rises 8+6*16 cycles after release.
REQ-039 SHALL cover: req0_valid=1, rs=1, data=0x41 in IDLE -> req0_ready for 1 cycle; lcd_rs=1 and lcd_data=0x41 the next cycle; lcd_e high cycles 5-8 after the grant edge; busy low again 16 cycles after the grant edge.
REQ-040 SHALL cover: both valid held with data 0x31 (req0) and 0x32 (req1) -> grants alternate req0, req1, req0, ...; lcd_data sequence 0x31, 0x32, 0x31, ...
REQ-041 SHALL cover: req1 changes data to 0x55 during PULSE -> lcd_data stays at the latched byte until HOLD exit.
REQ-042 SHALL cover: reset asserted during PULSE -> lcd_e=0 the next cycle, no ready, and the init sequence restarts.
REQ-043 SHALL cover: macro undefined, valid asserted in the first cycle after reset -> ready the same cycle; init_done=1 throughout.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-requester round-robin arbiter driving an HD44780-style
// write-only LCD bus. Each transfer is SETUP 1 ms, PULSE 1 ms (lcd_e high),
// HOLD 2 ms. Optional power-on/init sequence under macro LCD_ARB_INIT_SEQ_EN.
module lcd_bus_arbiter #(
  parameter int CNT1MS     = 100_000,
  parameter int POWERON_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam int             CW       = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT1MS - 1);
  localparam logic [15:0]    MS_ONE   = 16'd0;
  localparam logic [15:0]    MS_TWO   = 16'd1;
`ifdef LCD_ARB_INIT_SEQ_EN
  localparam logic [15:0]    MS_PWR   = 16'(POWERON_MS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
`ifdef LCD_ARB_INIT_SEQ_EN
    ,
    PWRON,
    INIT_SETUP,
    INIT_PULSE,
    INIT_HOLD
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   ms, ms_n;
  logic          rs_q, rs_n;
  logic [7:0]    data_q, data_n;
  logic          last, last_n;   // 1 = req1 was granted last
  logic          grant0, grant1;
  logic          cnt_wrap;
`ifdef LCD_ARB_INIT_SEQ_EN
  logic [2:0]    idx, idx_n;
  logic          done_q, done_n;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h08;
      3'd2:    init_cmd = 8'h01;
      3'd3:    init_cmd = 8'h06;
      3'd4:    init_cmd = 8'h0C;
      default: init_cmd = 8'h02;
    endcase
  endfunction
`endif

  assign cnt_wrap = (cnt == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef LCD_ARB_INIT_SEQ_EN
      state  <= PWRON;
      idx    <= '0;
      done_q <= 1'b0;
`else
      state  <= IDLE;
`endif
      cnt    <= '0;
      ms     <= '0;
      rs_q   <= 1'b0;
      data_q <= '0;
      last   <= 1'b1;
    end else begin
      state  <= state_n;
`ifdef LCD_ARB_INIT_SEQ_EN
      idx    <= idx_n;
      done_q <= done_n;
`endif
      cnt    <= cnt_n;
      ms     <= ms_n;
      rs_q   <= rs_n;
      data_q <= data_n;
      last   <= last_n;
    end
  end

  // Next-state, phase timing, arbitration and byte latching
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    ms_n    = ms;
    rs_n    = rs_q;
    data_n  = data_q;
    last_n  = last;
    grant0  = 1'b0;
    grant1  = 1'b0;
`ifdef LCD_ARB_INIT_SEQ_EN
    idx_n   = idx;
    done_n  = done_q;
`endif
    if (cnt_wrap) begin
      cnt_n = '0;
      ms_n  = ms + 16'd1;
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        ms_n  = '0;
        if (req0_valid && (!req1_valid || last)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0) begin
          state_n = SETUP;
          rs_n    = req0_rs;
          data_n  = req0_data;
          last_n  = 1'b0;
        end else if (grant1) begin
          state_n = SETUP;
          rs_n    = req1_rs;
          data_n  = req1_data;
          last_n  = 1'b1;
        end
      end
      SETUP: if (cnt_wrap && ms == MS_ONE) state_n = PULSE;
      PULSE: if (cnt_wrap && ms == MS_ONE) state_n = HOLD;
      HOLD:  if (cnt_wrap && ms == MS_TWO) state_n = IDLE;
`ifdef LCD_ARB_INIT_SEQ_EN
      PWRON: begin
        if (cnt_wrap && ms == MS_PWR) begin
          state_n = INIT_SETUP;
          idx_n   = '0;
          rs_n    = 1'b0;
          data_n  = init_cmd(3'd0);
        end
      end
      INIT_SETUP: if (cnt_wrap && ms == MS_ONE) state_n = INIT_PULSE;
      INIT_PULSE: if (cnt_wrap && ms == MS_ONE) state_n = INIT_HOLD;
      INIT_HOLD: begin
        if (cnt_wrap && ms == MS_TWO) begin
          if (idx == 3'd5) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = INIT_SETUP;
            idx_n   = idx + 3'd1;
            data_n  = init_cmd(idx + 3'd1);
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // Every state entry restarts the phase timers
    if (state_n != state) begin
      cnt_n = '0;
      ms_n  = '0;
    end
  end

  // Outputs; reset forces the bus quiet combinationally
`ifdef LCD_ARB_INIT_SEQ_EN
  assign lcd_e     = !reset && (state == PULSE || state == INIT_PULSE);
  assign init_done = !reset && done_q;
  assign busy      = reset ? 1'b1 : (state != IDLE);
`else
  assign lcd_e     = !reset && (state == PULSE);
  assign init_done = 1'b1;
  assign busy      = reset ? 1'b0 : (state != IDLE);
`endif
  assign lcd_rs     = !reset && rs_q;
  assign lcd_data   = reset ? '0 : data_q;
  assign lcd_rw     = 1'b0;
  assign req0_ready = !reset && grant0;
  assign req1_ready = !reset && grant1;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter (CNT1MS=4, POWERON_MS=2). Works with or
// without LCD_ARB_INIT_SEQ_EN defined.
module tb_lcd_bus_arbiter;

  localparam int CNT1MS      = 4;
  localparam int POWERON_MS  = 2;
  localparam int INIT_EDGES  = POWERON_MS * CNT1MS + 6 * 4 * CNT1MS;
  localparam int XFER_CYC    = 4 * CNT1MS;
`ifdef LCD_ARB_INIT_SEQ_EN
  localparam logic RST_BUSY  = 1'b1;
  localparam logic RST_DONE  = 1'b0;
`else
  localparam logic RST_BUSY  = 1'b0;
  localparam logic RST_DONE  = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_ready;
  logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_ready;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       lcd_e, lcd_rs, lcd_rw, init_done, busy;
  logic [7:0] lcd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(.CNT1MS(CNT1MS), .POWERON_MS(POWERON_MS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .init_done(init_done), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rs = 1'b0; req1_rs = 1'b0;
    req0_data = '0; req1_data = '0;
  endtask

  // Holds reset for three edges, checks quiet outputs, releases at a negedge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_init_done", init_done, RST_DONE);
    chk("rst_busy", busy, RST_BUSY);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 4 * INIT_EDGES && !ok; n++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  // Called right after reset release (at a negedge, before the first edge)
  task automatic post_reset();
`ifdef LCD_ARB_INIT_SEQ_EN
    logic [7:0] cmds [6] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h02};
    int   pulses = 0, width = 0, done_at = 0;
    logic prev_e = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hEE; req0_rs = 1'b1;
    for (int k = 1; k <= INIT_EDGES; k++) begin
      @(posedge clk); #1;
      if (lcd_e && !prev_e) begin
        if (pulses < 6) chk("init_cmd_byte", lcd_data, cmds[pulses]);
        chk("init_cmd_rs", lcd_rs, 0);
        pulses++;
        width = 0;
      end
      if (lcd_e) width++;
      if (!lcd_e && prev_e) chk("init_pulse_width", width, 4);
      if (!init_done) begin
        chk("init_ready0_quiet", req0_ready, 0);
        chk("init_ready1_quiet", req1_ready, 0);
      end else if (done_at == 0) begin
        done_at = k;
      end
      prev_e = lcd_e;
    end
    req0_valid = 1'b0;
    chk("init_pulse_count", pulses, 6);
    chk("init_done_edge", done_at, INIT_EDGES);
    chk("init_busy_after", busy, 0);
`else
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h77;
    #1;
    chk("noinit_ready_now", req1_ready, 1);
    chk("noinit_init_done", init_done, 1);
    chk("noinit_busy", busy, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("noinit_latched", lcd_data, 8'h77);
    chk("noinit_done_hold", init_done, 1);
    wait_idle();
`endif
  endtask

  typedef struct {
    logic       v0, v1, rs0, rs1;
    logic [7:0] d0, d1;
    logic       r0, r1, rs;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [7];

  // Transaction-level reference: rem = cycles left in the current transfer
  int         m_rem, m_last, m_g;
  logic       m_rs;
  logic [7:0] m_data;

  initial begin
    // Contention order starts from "req1 granted last" after reset
    vecs[0] = '{1, 1, 0, 1, 8'h31, 8'h32, 1, 0, 0, 8'h31};
    vecs[1] = '{1, 1, 0, 1, 8'h31, 8'h32, 0, 1, 1, 8'h32};
    vecs[2] = '{1, 1, 0, 1, 8'h31, 8'h32, 1, 0, 0, 8'h31};
    vecs[3] = '{1, 0, 1, 0, 8'h41, 8'h00, 1, 0, 1, 8'h41};
    vecs[4] = '{1, 1, 0, 0, 8'h10, 8'h20, 0, 1, 0, 8'h20};
    vecs[5] = '{0, 1, 0, 0, 8'h00, 8'h7E, 0, 1, 0, 8'h7E};
    vecs[6] = '{1, 1, 1, 0, 8'hA5, 8'h5A, 1, 0, 1, 8'hA5};

    do_reset();
    post_reset();

    // Table vectors: grant choice, then latched byte one cycle later
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      req0_rs = vecs[i].rs0;   req1_rs = vecs[i].rs1;
      req0_data = vecs[i].d0;  req1_data = vecs[i].d1;
      #1;
      chk("vec_ready0", req0_ready, vecs[i].r0);
      chk("vec_ready1", req1_ready, vecs[i].r1);
      @(posedge clk); #1;
      clear_inputs();
      chk("vec_lcd_data", lcd_data, vecs[i].data);
      chk("vec_lcd_rs", lcd_rs, vecs[i].rs);
      chk("vec_busy", busy, 1);
    end

    // Transfer timing, and data change on req1 during PULSE must not re-latch
    wait_idle();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    #1;
    chk("xfer_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= XFER_CYC + 1; k++) begin
      if (k == 6) begin req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h55; #1; end
      if (k == 12) begin req1_valid = 1'b0; #1; end
      chk("xfer_lcd_e", lcd_e, (k >= 5 && k <= 8));
      chk("xfer_busy", busy, (k <= XFER_CYC));
      if (k <= XFER_CYC) begin
        chk("xfer_data_stable", lcd_data, 8'h41);
        chk("xfer_rs_stable", lcd_rs, 1);
        chk("xfer_ready0_quiet", req0_ready, 0);
        chk("xfer_ready1_quiet", req1_ready, 0);
      end
      @(posedge clk); #1;
    end

    // Randomized traffic against the transaction-level model
    do_reset();
    post_reset();
    wait_idle();
    m_rem = 0; m_last = 1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 9) < 4);
      req1_valid = ($urandom_range(0, 9) < 4);
      req0_rs = 1'($urandom_range(0, 1));
      req1_rs = 1'($urandom_range(0, 1));
      req0_data = 8'($urandom_range(0, 255));
      req1_data = 8'($urandom_range(0, 255));
      #1;
      m_g = -1;
      if (m_rem == 0) begin
        if (req0_valid && req1_valid) m_g = (m_last == 0) ? 1 : 0;
        else if (req0_valid) m_g = 0;
        else if (req1_valid) m_g = 1;
      end
      chk("rnd_ready0", req0_ready, (m_g == 0));
      chk("rnd_ready1", req1_ready, (m_g == 1));
      chk("rnd_busy", busy, (m_rem > 0));
      chk("rnd_lcd_e", lcd_e, (m_rem >= 9 && m_rem <= 12));
      if (m_rem > 0) begin
        chk("rnd_lcd_data", lcd_data, m_data);
        chk("rnd_lcd_rs", lcd_rs, m_rs);
      end
      @(posedge clk);
      if (m_rem > 0) begin
        m_rem--;
      end else if (m_g >= 0) begin
        m_rem  = XFER_CYC;
        m_last = m_g;
        m_rs   = (m_g == 0) ? req0_rs : req1_rs;
        m_data = (m_g == 0) ? req0_data : req1_data;
      end
    end
    @(negedge clk);
    clear_inputs();

    // Reset during PULSE aborts the transfer and restarts from scratch
    wait_idle();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h66;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_in_pulse", lcd_e, 1);
    @(negedge clk);
    reset = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    chk("abort_lcd_e", lcd_e, 0);
    chk("abort_ready0", req0_ready, 0);
    chk("abort_ready1", req1_ready, 0);
    chk("abort_lcd_data", lcd_data, 0);
    chk("abort_init_done", init_done, RST_DONE);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    post_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
